rst_seq_ctrl: RTL and testbench

- Reset sequencer that sits directly after the chip reset input and drives the per-domain active-low resets.
- After power-on reset it holds every downstream domain in reset for a fixed time, then releases the domains one at a time in index order.
- In normal operation it accepts a software reset request for a selected subset of domains and re-runs the same timed sequence for that subset only.
- It reports busy, done and reset-cause status to the main FSM.

---
 rtl/rst_seq_ctrl.sv | 104 ++++++++++
 tb/tb_rst_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all target domains in reset for HOLD_CYC, then releases them in index order every STEP_CYC.
// First release HOLD_CYC cycles after start; soft requests arriving while busy are dropped, not queued.
module rst_seq_ctrl #(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             soft_rst_req,
  input  logic [N_DOM-1:0] soft_rst_mask,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             seq_busy,
  output logic             seq_done,
  output logic [1:0]       rst_cause,
  output logic [7:0]       soft_cnt
);

  typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_STEP, S_RUN} state_t;

  localparam int               STG_W     = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_DOM - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STG_W-1:0] stg;
  logic [STG_W-1:0] stg_nxt;
  logic [N_DOM-1:0] tgt;
  logic [N_DOM-1:0] rel_vec;
  logic             rel_meta;
  logic             req_q;
  logic             cnt_last;
  logic             soft_acc;

  // Stage to release when the current wait expires: 0 out of HOLD, k+1 out of STEP(k).
  always_comb begin
    stg_nxt  = (state == S_STEP) ? stg + 1'b1 : '0;
    rel_vec  = N_DOM'(1) << stg_nxt;
    cnt_last = (state == S_HOLD) ? (cnt == HOLD_LAST) : (cnt == STEP_LAST);
    soft_acc = (state == S_RUN) && soft_rst_req && !req_q && (soft_rst_mask != '0);
  end

  // rel_meta is the first synchronizer stage; the S_ASSERT exit is the second.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rel_meta  <= 1'b0;
      req_q     <= 1'b0;
      state     <= S_ASSERT;
      cnt       <= '0;
      stg       <= '0;
      tgt       <= '1;
      dom_rst_n <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
      rst_cause <= 2'b01;
      soft_cnt  <= 8'd0;
    end else begin
      rel_meta <= 1'b1;
      req_q    <= soft_rst_req;
      seq_done <= 1'b0;
      case (state)
        S_ASSERT: begin
          if (rel_meta) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD, S_STEP: begin
          if (cnt_last) begin
            cnt       <= '0;
            stg       <= stg_nxt;
            dom_rst_n <= dom_rst_n | (tgt & rel_vec);
            if (stg_nxt == STG_LAST) begin
              state    <= S_RUN;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (soft_acc) begin
            state     <= S_HOLD;
            cnt       <= '0;
            stg       <= '0;
            tgt       <= soft_rst_mask;
            dom_rst_n <= dom_rst_n & ~soft_rst_mask;
            seq_busy  <= 1'b1;
            rst_cause <= 2'b10;
            if (soft_cnt != 8'hFF) soft_cnt <= soft_cnt + 8'd1;
          end
        end
        default: state <= S_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: POR timing, soft reset subset, dropped requests, mid-sequence reset, counter saturation.
module tb_rst_seq_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [3:0] soft_rst_mask = 4'b0000;
  logic [3:0] dom_rst_n;
  logic       seq_busy;
  logic       seq_done;
  logic [1:0] rst_cause;
  logic [7:0] soft_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;
  int done_cnt = 0;
  int um_bad   = 0;
  int d0       = 0;
  int tmo      = 0;
  bit watch_um = 1'b0;

  rst_seq_ctrl #(.N_DOM(4), .HOLD_CYC(16), .STEP_CYC(8), .CNT_W(8)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .soft_rst_req  (soft_rst_req),
    .soft_rst_mask (soft_rst_mask),
    .dom_rst_n     (dom_rst_n),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done),
    .rst_cause     (rst_cause),
    .soft_cnt      (soft_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (seq_done) done_cnt++;
    if (watch_um && !(dom_rst_n[0] && dom_rst_n[2])) um_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to edge t (relative to the current sequence origin) and sample 1ns later.
  task automatic step_to(input int t);
    while (e < t) begin
      @(posedge clk_sys);
      e++;
    end
    #1;
  endtask

  // Drop rst between edges; T0 is the second rising edge afterwards.
  task automatic por_start();
    @(negedge clk_sys);
    rst = 1'b0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    e = 0;
    #1;
  endtask

  // Raise the request so that the next edge is the acceptance edge, which becomes the new origin.
  task automatic soft_start(input logic [3:0] m);
    soft_rst_mask = m;
    soft_rst_req  = 1'b1;
    @(posedge clk_sys);
    e = 0;
    #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dom", dom_rst_n, 4'b0000);
    chk("rst_busy", seq_busy, 1'b1);
    chk("rst_done", seq_done, 1'b0);
    chk("rst_cause", rst_cause, 2'b01);
    chk("rst_cnt", soft_cnt, 8'd0);

    // POR sequence
    por_start();
    chk("por_t0_dom", dom_rst_n, 4'b0000);
    step_to(15); chk("por_15", dom_rst_n, 4'b0000);
    step_to(16); chk("por_16", dom_rst_n, 4'b0001);
    step_to(23); chk("por_23", dom_rst_n, 4'b0001);
    step_to(24); chk("por_24", dom_rst_n, 4'b0011);
    step_to(32); chk("por_32", dom_rst_n, 4'b0111);
    step_to(39); chk("por_39_busy", seq_busy, 1'b1);
    chk("por_39_done", seq_done, 1'b0);
    step_to(40); chk("por_40", dom_rst_n, 4'b1111);
    chk("por_40_busy", seq_busy, 1'b0);
    chk("por_40_done", seq_done, 1'b1);
    step_to(41); chk("por_41_done", seq_done, 1'b0);
    chk("por_cause", rst_cause, 2'b01);
    chk("por_done_cnt", done_cnt, 1);

    // Soft reset of domains 1 and 3, request then held for 200 cycles
    step_to(50);
    d0 = done_cnt;
    watch_um = 1'b1;
    soft_start(4'b1010);
    chk("sa_dom", dom_rst_n, 4'b0101);
    chk("sa_busy", seq_busy, 1'b1);
    chk("sa_cause", rst_cause, 2'b10);
    chk("sa_cnt", soft_cnt, 8'd1);
    step_to(23); chk("sa_23", dom_rst_n, 4'b0101);
    step_to(24); chk("sa_24", dom_rst_n, 4'b0111);
    step_to(39); chk("sa_39", dom_rst_n, 4'b0111);
    step_to(40); chk("sa_40", dom_rst_n, 4'b1111);
    chk("sa_40_busy", seq_busy, 1'b0);
    chk("sa_40_done", seq_done, 1'b1);
    step_to(200);
    chk("held_cnt", soft_cnt, 8'd1);
    chk("held_busy", seq_busy, 1'b0);
    chk("held_done", done_cnt - d0, 1);
    chk("unmasked_stay", um_bad, 0);
    watch_um = 1'b0;
    soft_rst_req = 1'b0;

    // Rising request while busy is dropped; mask=0 in S_RUN is ignored
    step_to(203);
    d0 = done_cnt;
    soft_start(4'b0001);
    chk("sb_dom", dom_rst_n, 4'b1110);
    chk("sb_cnt", soft_cnt, 8'd2);
    soft_rst_req = 1'b0;
    step_to(9);
    soft_rst_req = 1'b1;
    step_to(11);
    chk("busy_drop_cnt", soft_cnt, 8'd2);
    chk("busy_drop_busy", seq_busy, 1'b1);
    step_to(16); chk("sb_16", dom_rst_n, 4'b1111);
    step_to(40); chk("sb_40_busy", seq_busy, 1'b0);
    step_to(41);
    chk("sb_done", done_cnt - d0, 1);
    chk("sb_cnt_end", soft_cnt, 8'd2);
    soft_rst_req = 1'b0;
    step_to(43);
    soft_rst_mask = 4'b0000;
    soft_rst_req  = 1'b1;
    step_to(50);
    chk("m0_busy", seq_busy, 1'b0);
    chk("m0_cnt", soft_cnt, 8'd2);
    chk("m0_done", done_cnt - d0, 1);
    chk("m0_dom", dom_rst_n, 4'b1111);
    soft_rst_req = 1'b0;

    // Asynchronous reset clears soft state, then rst mid-POR at T0+28
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dom", dom_rst_n, 4'b0000);
    chk("arst_busy", seq_busy, 1'b1);
    chk("arst_cause", rst_cause, 2'b01);
    chk("arst_cnt", soft_cnt, 8'd0);
    por_start();
    step_to(28); chk("mid_28", dom_rst_n, 4'b0011);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_arst_dom", dom_rst_n, 4'b0000);
    chk("mid_arst_busy", seq_busy, 1'b1);
    por_start();
    step_to(15); chk("rp_15", dom_rst_n, 4'b0000);
    step_to(16); chk("rp_16", dom_rst_n, 4'b0001);
    step_to(40); chk("rp_40", dom_rst_n, 4'b1111);
    chk("rp_40_busy", seq_busy, 1'b0);
    chk("rp_cause", rst_cause, 2'b01);
    chk("rp_cnt", soft_cnt, 8'd0);
    step_to(42);

    // 300 accepted soft resets: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      soft_start(4'b1111);
      soft_rst_req = 1'b0;
      begin
        int w;
        w = 0;
        while (seq_busy && w < 60) begin
          @(posedge clk_sys);
          #1;
          w++;
        end
        if (seq_busy) tmo++;
      end
      if (i == 253) chk("sat_254", soft_cnt, 8'd254);
      if (i == 254) chk("sat_255", soft_cnt, 8'd255);
    end
    chk("sat_timeouts", tmo, 0);
    chk("sat_final", soft_cnt, 8'd255);
    chk("sat_dom", dom_rst_n, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
